// File: rtl/pipe_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_if
// Groups the pipeline-control signals exchanged between the pipeline stages
// and the pipe_ctrl block.
//   stallreq_if/id/ex/mem : per-stage stall requests        (to pipe_ctrl)
//   mem_except_type       : MEM-stage exception code, 0=none (to pipe_ctrl)
//   cp0_epc               : current CP0 EPC                  (to pipe_ctrl)
//   stall_ctrl            : per-stage stall, bit0 PC .. bit5 WB
//   flush, new_pc         : pipeline flush and redirect address
//   stall_timeout         : sticky "stall exceeded limit" flag
//   stall_cycles          : saturating count of stalled cycles
//   exc_count             : wrapping count of flushes taken
// Modports: master = pipeline side, slave = pipe_ctrl side.
// ----------------------------------------------------------------------------
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] mem_except_type;
  logic [31:0] cp0_epc;
  logic [5:0]  stall_ctrl;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] exc_count;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output mem_except_type, cp0_epc,
    input  stall_ctrl, flush, new_pc, stall_timeout, stall_cycles, exc_count
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  mem_except_type, cp0_epc,
    output stall_ctrl, flush, new_pc, stall_timeout, stall_cycles, exc_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline hazard/exception controller. Produces per-stage stall controls
// from the stage stall requests (deepest stage wins), and on a MEM-stage
// exception flushes the pipeline and redirects fetch to either the EPC (ERET)
// or the exception vector. A one-cycle GUARD state after each flush ignores
// the exception input so the same exception is not taken twice back-to-back.
// Also tracks stall statistics and a sticky stall-timeout flag.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-low reset
//   bus  : pipe_ctrl_if.slave (stall requests, exception info, controls,
//          statistics)
// stall_ctrl/flush/new_pc are combinational; counters/flags are registered.
// ----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [7:0]  STALL_LIMIT = 8'd255
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [31:0] ERET_CODE = 32'h0000_000e;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    GUARD = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        flush_s;
  logic [31:0] new_pc_s;
  logic [5:0]  stall_ctrl_s;
  logic        stall_active_s;
  logic [7:0]  stall_run_r;
  logic        stall_timeout_r;
  logic [31:0] stall_cycles_r;
  logic [15:0] exc_count_r;

  // Stall mask for the deepest requesting stage; a stage stalls itself and
  // everything upstream of it.
  function automatic logic [5:0] stall_mask(input logic req_if, input logic req_id,
                                            input logic req_ex, input logic req_mem);
    logic [5:0] mask;
    if (req_mem) begin
      mask = 6'b011111;
    end else if (req_ex) begin
      mask = 6'b001111;
    end else if (req_id) begin
      mask = 6'b000111;
    end else if (req_if) begin
      mask = 6'b000011;
    end else begin
      mask = 6'b000000;
    end
    return mask;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, flush/redirect and stall control; reset forces all idle
  always_comb begin
    state_nxt_s  = RUN;
    flush_s      = 1'b0;
    new_pc_s     = 32'h0000_0000;
    stall_ctrl_s = 6'b000000;
    case (state_r)
      RUN: begin
        if (bus.mem_except_type != 32'h0000_0000) begin
          flush_s     = 1'b1;
          state_nxt_s = GUARD;
          if (bus.mem_except_type == ERET_CODE) begin
            new_pc_s = bus.cp0_epc;
          end else begin
            new_pc_s = EXC_VECTOR;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      GUARD: begin
        state_nxt_s = RUN;
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase

    if (!rst) begin
      flush_s      = 1'b0;
      new_pc_s     = 32'h0000_0000;
      stall_ctrl_s = 6'b000000;
    end else if (flush_s) begin
      // An exception overrides every stall request in its cycle.
      stall_ctrl_s = 6'b000000;
    end else begin
      stall_ctrl_s = stall_mask(bus.stallreq_if, bus.stallreq_id,
                                bus.stallreq_ex, bus.stallreq_mem);
    end
  end

  assign stall_active_s = (stall_ctrl_s != 6'b000000);

  // Consecutive-stall run length, saturating, cleared by any non-stall cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_run_r <= 8'd0;
    end else if (flush_s || !stall_active_s) begin
      stall_run_r <= 8'd0;
    end else if (stall_run_r != 8'hFF) begin
      stall_run_r <= stall_run_r + 8'd1;
    end else begin
      stall_run_r <= stall_run_r;
    end
  end

  // Sticky stall-timeout flag; a flush clears it even if it would set now
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_timeout_r <= 1'b0;
    end else if (flush_s) begin
      stall_timeout_r <= 1'b0;
    end else if (stall_active_s && (stall_run_r == STALL_LIMIT)) begin
      stall_timeout_r <= 1'b1;
    end else begin
      stall_timeout_r <= stall_timeout_r;
    end
  end

  // Total stalled-cycle counter, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_r <= 32'd0;
    end else if (stall_active_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  // Flush counter, wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_count_r <= 16'd0;
    end else if (flush_s) begin
      exc_count_r <= exc_count_r + 16'd1;
    end else begin
      exc_count_r <= exc_count_r;
    end
  end

  assign bus.stall_ctrl    = stall_ctrl_s;
  assign bus.flush         = flush_s;
  assign bus.new_pc        = new_pc_s;
  assign bus.stall_timeout = stall_timeout_r;
  assign bus.stall_cycles  = stall_cycles_r;
  assign bus.exc_count     = exc_count_r;

endmodule
